// File: rtl/intt_iterative.sv
// Iterative inverse NTT: bit-reversed spectrum in, natural-order time samples out, scaled by N^-1.
// A single radix-2 DIT butterfly is time-shared over all (N/2)*log2(N) butterflies of the transform.
module intt_iterative #(
    parameter int unsigned W         = 32,
    parameter int unsigned N         = 8,
    parameter int unsigned Modulus_Q = 17,
    parameter int unsigned OMEGA_INV = 9,
    parameter int unsigned N_INV     = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned SW   = $clog2(LOGN);
    localparam int unsigned HW   = LOGN - 1;

    localparam logic [W-1:0]   Q_W    = W'(Modulus_Q);
    localparam logic [W:0]     Q_W1   = (W + 1)'(Modulus_Q);
    localparam logic [2*W-1:0] Q_2W   = (2 * W)'(Modulus_Q);
    localparam logic [W-1:0]   NINV_W = W'(N_INV);

    typedef enum logic [1:0] {
        StLoad,
        StCompute,
        StUnload
    } state_e;

    // Twiddle TW[j] = OMEGA_INV^j mod Q, folded to constants at elaboration.
    function automatic logic [W-1:0] tw_pow(input int unsigned j);
        longint unsigned acc;
        acc = 64'd1;
        for (int unsigned i = 0; i < j; i++) begin
            acc = (acc * 64'(OMEGA_INV)) % 64'(Modulus_Q);
        end
        return W'(acc);
    endfunction

    logic [W-1:0] w_tw [N/2];

    for (genvar j = 0; j < N / 2; j++) begin : g_tw
        assign w_tw[j] = tw_pow(j);
    end

    state_e          r_state;
    state_e          w_state_next;
    logic [LOGN-1:0] r_cnt;
    logic [SW-1:0]   r_stage;
    logic [HW-1:0]   r_idx;
    logic [LOGN-1:0] r_k;
    logic [W-1:0]    r_buf [N];

    logic            w_load_fire;
    logic            w_out_fire;
    logic            w_last_bfly;

    logic [LOGN-1:0] w_idx_ext;
    logic [LOGN-1:0] w_stride;
    logic [LOGN-1:0] w_bfly;
    logic [LOGN-1:0] w_top;
    logic [LOGN-1:0] w_bot;
    logic [HW-1:0]   w_tw_idx;

    logic [W-1:0]    w_in_red;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_m;
    logic [W:0]      w_sum;
    logic [W:0]      w_dif;
    logic [W-1:0]    w_add;
    logic [W-1:0]    w_sub;
    logic [2*W-1:0]  w_oprod;
    logic [W-1:0]    w_scaled;

    assign w_load_fire = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_last_bfly = (r_stage == SW'(LOGN - 1)) && (r_idx == {HW{1'b1}});

    // Stage s, linear index i: group g = i >> s, b = i mod 2^s, t = g*2^(s+1) + b.
    always_comb begin
        w_idx_ext = {1'b0, r_idx};
        w_stride  = LOGN'(1) << r_stage;
        w_bfly    = w_idx_ext & (w_stride - LOGN'(1));
        w_top     = ((w_idx_ext >> r_stage) << (32'(r_stage) + 32'd1)) | w_bfly;
        w_bot     = w_top + w_stride;
        w_tw_idx  = HW'(w_bfly << (LOGN - 32'd1 - 32'(r_stage)));
    end

    always_comb begin
        w_in_red = in_data % Q_W;
        w_a      = r_buf[w_top];
        w_b      = r_buf[w_bot];
        w_prod   = {{W{1'b0}}, w_tw[w_tw_idx]} * {{W{1'b0}}, w_b};
        w_m      = W'(w_prod % Q_2W);
        w_sum    = {1'b0, w_a} + {1'b0, w_m};
        w_dif    = {1'b0, w_a} + Q_W1 - {1'b0, w_m};
        w_add    = W'((w_sum >= Q_W1) ? (w_sum - Q_W1) : w_sum);
        w_sub    = W'((w_dif >= Q_W1) ? (w_dif - Q_W1) : w_dif);
        w_oprod  = {{W{1'b0}}, r_buf[r_k]} * {{W{1'b0}}, NINV_W};
        w_scaled = W'(w_oprod % Q_2W);
    end

    // Buffer contents need no reset; every frame overwrites all N entries before use.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_buf[r_cnt] <= w_in_red;
        end else if (r_state == StCompute) begin
            r_buf[w_top] <= w_add;
            r_buf[w_bot] <= w_sub;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_stage <= '0;
            r_idx   <= '0;
            r_k     <= '0;
        end else begin
            if (w_load_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == StCompute) begin
                r_idx <= r_idx + 1'b1;
                if (r_idx == {HW{1'b1}}) begin
                    r_stage <= w_last_bfly ? '0 : r_stage + 1'b1;
                end
            end
            if (w_out_fire) begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StLoad: begin
                if (w_load_fire && (r_cnt == LOGN'(N - 1))) begin
                    w_state_next = StCompute;
                end
            end
            StCompute: begin
                if (w_last_bfly) begin
                    w_state_next = StUnload;
                end
            end
            StUnload: begin
                if (w_out_fire && (r_k == LOGN'(N - 1))) begin
                    w_state_next = StLoad;
                end
            end
            default: w_state_next = StLoad;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (r_state)
            StLoad: begin
                in_ready = 1'b1;
            end
            StCompute: begin
                busy = 1'b1;
            end
            StUnload: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = w_scaled;
                out_last  = (r_k == LOGN'(N - 1));
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
